aes128_key_expand: RTL

- Iterative AES-128 key schedule. Sits directly downstream of the AES-128 key register and consumes its key_o/key_valid_o outputs.
- On a start request it streams the 11 round keys (round 0 to 10), one per valid/ready handshake, to the cipher datapath.
- Round keys are computed on the fly from a single 128-bit working register; the full schedule is never stored.

---
 rtl/aes128_pkg.sv | 32 +++
 rtl/aes128_sbox.sv | 29 ++
 rtl/aes128_key_expand.sv | 139 +++++++++++++
 3 files changed

// File: rtl/aes128_pkg.sv
// Shared types and constants for the iterative AES-128 key schedule.
package aes128_pkg;

    localparam int AES128_NUM_ROUNDS = 10;

    typedef logic [127:0] aes128_key_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } aes128_state_e;

    // Round constant consumed when stepping from round idx to idx+1.
    function automatic logic [7:0] aes128_rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes128_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes128_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry 0 sits in the top byte, entry 255 in the bottom byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = SBOX_TABLE[11'd2047 - {i_byte, 3'b000} -: 8];

endmodule

// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key schedule streaming round keys 0..10 over valid/ready.
// Optional build macro AES128_KEY_EXPAND_ZEROIZE_EN clears the working key on return to idle.
module aes128_key_expand
    import aes128_pkg::*;
#(
    parameter bit ResetAll = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  aes128_key_t   key_i,
    input  logic          key_valid_i,
    input  logic          start_i,
    output aes128_key_t   rk_o,
    output logic [3:0]    rk_idx_o,
    output logic          rk_valid_o,
    input  logic          rk_ready_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output aes128_state_e dbg_state_o
);

    // Handshake: a round key transfers on a rising clk_i edge where rk_valid_o
    // and rk_ready_i are both high; rk_o/rk_idx_o hold while valid && !ready.

    aes128_state_e r_state, w_state_d;
    logic [3:0]    r_idx, w_idx_d;
    aes128_key_t   r_rk, w_rk_d, w_rk_next;
    logic          r_done, w_done_d;
    logic          r_err, w_err_d;

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot, w_sub, w_t;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign {w_w0, w_w1, w_w2, w_w3} = r_rk;
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes128_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_t       = w_sub ^ {aes128_rcon(r_idx), 24'h000000};
    assign w_n0      = w_w0 ^ w_t;
    assign w_n1      = w_w1 ^ w_n0;
    assign w_n2      = w_w2 ^ w_n1;
    assign w_n3      = w_w3 ^ w_n2;
    assign w_rk_next = {w_n0, w_n1, w_n2, w_n3};

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_rk_d    = r_rk;
        w_done_d  = 1'b0;
        w_err_d   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (key_valid_i) begin
                        w_state_d = ST_RUN;
                        w_idx_d   = 4'd0;
                        w_rk_d    = key_i;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Losing the key outranks any handshake in the same cycle.
                if (!key_valid_i) begin
                    w_state_d = ST_IDLE;
                    w_idx_d   = 4'd0;
                    w_err_d   = 1'b1;
`ifdef AES128_KEY_EXPAND_ZEROIZE_EN
                    w_rk_d    = '0;
`endif
                end else if (rk_ready_i) begin
                    if (r_idx == 4'(AES128_NUM_ROUNDS)) begin
                        w_state_d = ST_IDLE;
                        w_idx_d   = 4'd0;
                        w_done_d  = 1'b1;
`ifdef AES128_KEY_EXPAND_ZEROIZE_EN
                        w_rk_d    = '0;
`endif
                    end else begin
                        w_idx_d = r_idx + 4'd1;
                        w_rk_d  = w_rk_next;
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            r_done  <= w_done_d;
            r_err   <= w_err_d;
        end
    end

    if (ResetAll) begin : g_rk_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_rk <= '0;
            end else begin
                r_rk <= w_rk_d;
            end
        end
    end else begin : g_rk_nrst
        always_ff @(posedge clk_i) begin
            r_rk <= w_rk_d;
        end
    end

    assign rk_valid_o  = (r_state == ST_RUN);
    assign busy_o      = (r_state == ST_RUN);
    assign rk_idx_o    = r_idx;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign dbg_state_o = r_state;

`ifdef AES128_KEY_EXPAND_ZEROIZE_EN
    assign rk_o = rk_valid_o ? r_rk : '0;
`else
    assign rk_o = r_rk;
`endif

endmodule
